// File: rtl/qspi_pkg.sv
// Shared opcodes and FSM states for the serial SRAM responder.
package qspi_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_EQIO  = 8'h38;
   localparam logic [7:0] CMD_RSTIO = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RDATA,
      WDATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/qspi_pin_sync.sv
// Pad synchronizers and single-CLK edge pulses for SCK and CS_N.
// SIO shares the SCK delay so its value lines up with each edge pulse.
module qspi_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_res,
   input  logic       i_sck,
   input  logic       i_cs_n,
   input  logic [3:0] i_sio,
   output logic       o_sck_rise,
   output logic       o_sck_fall,
   output logic       o_cs_fall,
   output logic       o_cs_rise,
   output logic       o_cs_n,
   output logic [3:0] o_sio
);

   logic [STAGES-1:0]      r_sck;
   logic [STAGES-1:0]      r_cs;
   logic [STAGES-1:0][3:0] r_sio;
   logic                   r_sck_d;
   logic                   r_cs_d;

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_sck   <= '0;
         r_cs    <= '1;
         r_sio   <= '0;
         r_sck_d <= 1'b0;
         r_cs_d  <= 1'b1;
      end else begin
         r_sck   <= {r_sck[STAGES-2:0], i_sck};
         r_cs    <= {r_cs[STAGES-2:0], i_cs_n};
         r_sio   <= {r_sio[STAGES-2:0], i_sio};
         r_sck_d <= r_sck[STAGES-1];
         r_cs_d  <= r_cs[STAGES-1];
      end
   end

   assign o_sck_rise = r_sck[STAGES-1] & ~r_sck_d;
   assign o_sck_fall = ~r_sck[STAGES-1] & r_sck_d;
   assign o_cs_fall  = ~r_cs[STAGES-1] & r_cs_d;
   assign o_cs_rise  = r_cs[STAGES-1] & ~r_cs_d;
   assign o_cs_n     = r_cs[STAGES-1];
   assign o_sio      = r_sio[STAGES-1];

endmodule

// File: rtl/qspi_sram_responder.sv
// 23LC512-style SPI/SQI serial SRAM responder driving a
// synchronous byte memory port from oversampled pad signals.
module qspi_sram_responder
   import qspi_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              QSPI_CS_N,
   input  logic              QSPI_SCK,
   input  logic [3:0]        QSPI_SIO_I,
   output logic [3:0]        QSPI_SIO_O,
   output logic [3:0]        QSPI_SIO_E,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_RE,
   output logic              MEM_WE,
   output logic [7:0]        MEM_WDATA,
   input  logic [7:0]        MEM_RDATA,
   output logic              SQI_MODE
);

   localparam int CW = $clog2(ADDR_W + 1);

   logic              w_sck_rise;
   logic              w_sck_fall;
   logic              w_cs_fall;
   logic              w_cs_rise;
   logic              w_cs_n;
   logic [3:0]        w_sio;

   state_t            r_state;
   state_t            w_state_nx;

   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_step;
   logic [CW-1:0]     w_cnt_nx;
   logic [7:0]        r_shift;
   logic [7:0]        w_byte_in;
   logic [7:0]        w_rd_byte;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_in;
   logic              r_is_read;
   logic              r_sqi;
   logic              r_pend_eq;
   logic              r_pend_rst;
   logic              r_re;
   logic              r_we;
   logic              r_drv;
   logic [7:0]        r_wdata;
   logic [3:0]        r_sio_o;

   logic              w_active;
   logic              w_byte_done;
   logic              w_addr_done;
   logic              w_rd_last;

   qspi_pin_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk     (CLK),
      .i_res     (RES),
      .i_sck     (QSPI_SCK),
      .i_cs_n    (QSPI_CS_N),
      .i_sio     (QSPI_SIO_I),
      .o_sck_rise(w_sck_rise),
      .o_sck_fall(w_sck_fall),
      .o_cs_fall (w_cs_fall),
      .o_cs_rise (w_cs_rise),
      .o_cs_n    (w_cs_n),
      .o_sio     (w_sio)
   );

   assign w_active  = ~w_cs_n;
   assign w_step    = r_sqi ? CW'(4) : CW'(1);
   assign w_cnt_nx  = r_cnt + w_step;

   assign w_byte_in = r_sqi ? {r_shift[3:0], w_sio}
                            : {r_shift[6:0], w_sio[0]};
   assign w_addr_in = r_sqi ? {r_addr[ADDR_W-5:0], w_sio}
                            : {r_addr[ADDR_W-2:0], w_sio[0]};

   assign w_byte_done = w_active & w_sck_rise
                      & (w_cnt_nx == CW'(8));
   assign w_addr_done = w_active & w_sck_rise
                      & (w_cnt_nx == CW'(ADDR_W));

   // First slice of each byte comes straight from the memory port.
   assign w_rd_byte = (r_cnt == '0) ? MEM_RDATA : r_shift;
   assign w_rd_last = (w_cnt_nx == CW'(8));

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (!w_active) begin
         w_state_nx = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_cs_fall) w_state_nx = CMD;
            end
            CMD: begin
               if (w_byte_done) begin
                  case (w_byte_in)
                     CMD_READ,
                     CMD_WRITE: w_state_nx = ADDR;
                     default:   w_state_nx = IGNORE;
                  endcase
               end
            end
            ADDR: begin
               if (w_addr_done) begin
                  if (!r_is_read)  w_state_nx = WDATA;
                  else if (r_sqi)  w_state_nx = DUMMY;
                  else             w_state_nx = RDATA;
               end
            end
            DUMMY: begin
               if (w_byte_done) w_state_nx = RDATA;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_addr     <= '0;
         r_is_read  <= 1'b0;
         r_sqi      <= 1'b0;
         r_pend_eq  <= 1'b0;
         r_pend_rst <= 1'b0;
         r_re       <= 1'b0;
         r_we       <= 1'b0;
         r_drv      <= 1'b0;
         r_wdata    <= '0;
         r_sio_o    <= '0;
      end else begin
         r_re <= 1'b0;
         r_we <= 1'b0;
         if (r_we) r_addr <= r_addr + ADDR_W'(1);

         // Mode changes only take effect once the frame closes.
         if (w_cs_rise) begin
            if (r_pend_eq)  r_sqi <= 1'b1;
            if (r_pend_rst) r_sqi <= 1'b0;
            r_pend_eq  <= 1'b0;
            r_pend_rst <= 1'b0;
         end

         if (!w_active) begin
            r_cnt <= '0;
            r_drv <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  r_cnt <= '0;
                  r_drv <= 1'b0;
               end
               CMD: begin
                  if (w_sck_rise) begin
                     r_shift <= w_byte_in;
                     r_cnt   <= w_byte_done ? '0 : w_cnt_nx;
                  end
                  if (w_byte_done) begin
                     r_is_read  <= (w_byte_in == CMD_READ);
                     r_pend_eq  <= (w_byte_in == CMD_EQIO);
                     r_pend_rst <= (w_byte_in == CMD_RSTIO);
                  end
               end
               ADDR: begin
                  if (w_sck_rise) begin
                     r_addr <= w_addr_in;
                     r_cnt  <= w_addr_done ? '0 : w_cnt_nx;
                  end
                  if (w_addr_done && r_is_read && !r_sqi) r_re <= 1'b1;
               end
               DUMMY: begin
                  if (w_sck_rise) r_cnt <= w_byte_done ? '0 : w_cnt_nx;
                  if (w_byte_done) r_re <= 1'b1;
               end
               RDATA: begin
                  if (w_sck_fall) begin
                     r_drv   <= 1'b1;
                     r_sio_o <= r_sqi ? w_rd_byte[7:4]
                                      : {2'b00, w_rd_byte[7], 1'b0};
                     r_shift <= r_sqi ? {w_rd_byte[3:0], 4'h0}
                                      : {w_rd_byte[6:0], 1'b0};
                     r_cnt   <= w_rd_last ? '0 : w_cnt_nx;
                     // Prefetch so the next byte is ready a full SCK early.
                     if (w_rd_last) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_re   <= 1'b1;
                     end
                  end
               end
               WDATA: begin
                  if (w_sck_rise) begin
                     r_shift <= w_byte_in;
                     r_cnt   <= w_byte_done ? '0 : w_cnt_nx;
                  end
                  if (w_byte_done) begin
                     r_we    <= 1'b1;
                     r_wdata <= w_byte_in;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign QSPI_SIO_O = r_sio_o;
   assign QSPI_SIO_E = (r_state == RDATA && r_drv && w_active)
                     ? (r_sqi ? 4'hF : 4'b0010) : 4'h0;
   assign MEM_ADDR   = r_addr;
   assign MEM_RE     = r_re;
   assign MEM_WE     = r_we;
   assign MEM_WDATA  = r_wdata;
   assign SQI_MODE   = r_sqi;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Bus-master bench for qspi_sram_responder with an SRAM peer and
// an array reference model of expected memory contents.
module tb_qspi_sram_responder;

   localparam int AW = 16;

   logic          clk   = 1'b0;
   logic          res   = 1'b1;
   logic          cs_n  = 1'b1;
   logic          sck   = 1'b0;
   logic [3:0]    sio_i = 4'h0;
   logic [3:0]    sio_o;
   logic [3:0]    sio_e;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata = 8'h00;
   logic          sqi_mode;

   logic [7:0]    mem   [0:65535];
   bit            wr    [0:65535];
   logic [7:0]    model [0:65535];
   logic [AW+7:0] we_q  [$];
   logic [AW-1:0] re_q  [$];
   logic [7:0]    wbuf  [$];
   logic [7:0]    salt;
   int            checks = 0;
   int            errors = 0;
   bit            quad   = 1'b0;
   bit            e_leak = 1'b0;

   always #5 clk = ~clk;

   qspi_sram_responder #(
      .ADDR_W(AW),
      .SYNC_STAGES(2)
   ) dut (
      .CLK       (clk),
      .RES       (res),
      .QSPI_CS_N (cs_n),
      .QSPI_SCK  (sck),
      .QSPI_SIO_I(sio_i),
      .QSPI_SIO_O(sio_o),
      .QSPI_SIO_E(sio_e),
      .MEM_ADDR  (mem_addr),
      .MEM_RE    (mem_re),
      .MEM_WE    (mem_we),
      .MEM_WDATA (mem_wdata),
      .MEM_RDATA (mem_rdata),
      .SQI_MODE  (sqi_mode)
   );

   function automatic logic [7:0] seed(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ salt;
   endfunction

   // Synchronous SRAM peer: unwritten locations return seed().
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr[mem_addr]  <= 1'b1;
         we_q.push_back({mem_addr, mem_wdata});
      end
      if (mem_re) begin
         mem_rdata <= wr[mem_addr] ? mem[mem_addr] : seed(mem_addr);
         re_q.push_back(mem_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [3:0] din, output logic [3:0] dout,
                        output logic [3:0] e);
      sio_i = din;
      repeat (8) @(negedge clk);
      dout = sio_o;
      e    = sio_e;
      sck  = 1'b1;
      repeat (8) @(negedge clk);
      sck  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [3:0] d, e;
      if (quad) begin
         for (int i = 0; i < 2; i++) begin
            pulse(b[7-4*i -: 4], d, e);
            if (e != 4'h0) e_leak = 1'b1;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            pulse({3'b000, b[7-i]}, d, e);
            if (e != 4'h0) e_leak = 1'b1;
         end
      end
   endtask

   task automatic read_byte(input string tag, output logic [7:0] b);
      logic [3:0] d, e;
      b = 8'h00;
      if (quad) begin
         for (int i = 0; i < 2; i++) begin
            pulse(4'h0, d, e);
            b = {b[3:0], d};
            chk({tag, "_oe"}, e, 4'hF);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            pulse(4'h0, d, e);
            b = {b[6:0], d[1]};
            chk({tag, "_oe"}, e, 4'b0010);
         end
      end
   endtask

   task automatic start();
      cs_n   = 1'b0;
      e_leak = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic stop();
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("oe_release", sio_e, 4'h0);
      repeat (6) @(negedge clk);
   endtask

   task automatic do_write(input logic [15:0] a, input string tag);
      int base;
      logic [15:0] ea;
      base = we_q.size();
      start();
      send_byte(8'h02);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      foreach (wbuf[i]) send_byte(wbuf[i]);
      stop();
      chk({tag, "_we_n"}, we_q.size() - base, wbuf.size());
      foreach (wbuf[i]) begin
         ea = a + 16'(i);
         model[ea] = wbuf[i];
         if (base + i < we_q.size())
            chk({tag, "_we"}, we_q[base+i], {ea, wbuf[i]});
      end
      chk({tag, "_oe_leak"}, e_leak, 1'b0);
   endtask

   task automatic do_read(input logic [15:0] a, input int n,
                          input string tag);
      int base;
      logic [7:0] b;
      base = re_q.size();
      start();
      send_byte(8'h03);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      if (quad) send_byte(8'h00);
      chk({tag, "_oe_leak"}, e_leak, 1'b0);
      for (int i = 0; i < n; i++) begin
         read_byte(tag, b);
         chk({tag, "_data"}, b, model[16'(a + 16'(i))]);
      end
      stop();
      chk({tag, "_re_n"}, re_q.size() - base, n + 1);
      for (int i = 0; i <= n; i++) begin
         if (base + i < re_q.size())
            chk({tag, "_re_addr"}, re_q[base+i], 16'(a + 16'(i)));
      end
   endtask

   task automatic rand_wbuf();
      int n;
      wbuf.delete();
      n = $urandom_range(1, 4);
      repeat (n) wbuf.push_back(8'($urandom));
   endtask

   task automatic eqio();
      start();
      send_byte(8'h38);
      chk("eqio_hold", sqi_mode, 1'b0);
      stop();
      quad = 1'b1;
      chk("eqio_mode", sqi_mode, 1'b1);
   endtask

   initial begin
      logic [3:0]  d, e;
      logic [15:0] a;
      int          base;

      salt = 8'($urandom);
      for (int i = 0; i < 65536; i++) model[i] = seed(16'(i));

      repeat (3) @(negedge clk);
      chk("rst_sio_o", sio_o, 4'h0);
      chk("rst_sio_e", sio_e, 4'h0);
      chk("rst_re", mem_re, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_sqi", sqi_mode, 1'b0);
      res = 1'b0;
      repeat (4) @(negedge clk);

      wbuf.delete();
      wbuf.push_back(8'hA5);
      wbuf.push_back(8'h3C);
      do_write(16'h0010, "spi_wr");
      do_read(16'h0010, 2, "spi_rd");

      repeat (3) begin
         a = 16'($urandom);
         rand_wbuf();
         do_write(a, "rnd_spi_wr");
         do_read(a, wbuf.size(), "rnd_spi_rd");
      end
      do_read(16'($urandom), 2, "spi_rd_seed");

      // Frame closed after half a data byte: nothing is written.
      base = we_q.size();
      start();
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      for (int i = 0; i < 4; i++) pulse(4'h1, d, e);
      stop();
      chk("abort_we", we_q.size() - base, 0);
      do_read(16'h1234, 1, "post_abort");

      eqio();
      wbuf.delete();
      wbuf.push_back(8'h11);
      wbuf.push_back(8'h22);
      do_write(16'hFFFF, "sqi_wr_wrap");
      do_read(16'hFFFF, 2, "sqi_rd_wrap");
      wbuf.delete();
      wbuf.push_back(8'h66);
      wbuf.push_back(8'h77);
      do_write(16'h8006, "sqi_wr");
      do_read(16'h8006, 2, "sqi_rd");

      repeat (2) begin
         a = 16'($urandom);
         rand_wbuf();
         do_write(a, "rnd_sqi_wr");
         do_read(a, wbuf.size(), "rnd_sqi_rd");
      end

      base = we_q.size();
      start();
      send_byte(8'h5A);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h99);
      stop();
      chk("badop_we", we_q.size() - base, 0);
      chk("badop_oe_leak", e_leak, 1'b0);
      chk("badop_mode", sqi_mode, 1'b1);

      start();
      send_byte(8'hFF);
      chk("rstio_hold", sqi_mode, 1'b1);
      stop();
      quad = 1'b0;
      chk("rstio_mode", sqi_mode, 1'b0);
      do_read(16'h0010, 2, "spi_after_rstio");

      // Reset in the middle of an SQI data phase.
      eqio();
      start();
      send_byte(8'h03);
      send_byte(8'h80);
      send_byte(8'h06);
      send_byte(8'h00);
      pulse(4'h0, d, e);
      chk("mid_oe_on", e, 4'hF);
      chk("mid_nib", d, 4'h6);
      res = 1'b1;
      @(negedge clk);
      chk("mid_res_oe", sio_e, 4'h0);
      chk("mid_res_sqi", sqi_mode, 1'b0);
      chk("mid_res_addr", mem_addr, 16'h0000);
      cs_n = 1'b1;
      quad = 1'b0;
      repeat (4) @(negedge clk);
      res = 1'b0;
      repeat (4) @(negedge clk);

      a = 16'($urandom);
      rand_wbuf();
      do_write(a, "final_wr");
      do_read(a, wbuf.size(), "final_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
